// File: rtl/nrzi_destuff_rx_if.sv
// -----------------------------------------------------------------------------
// nrzi_destuff_rx_if
//   Bundle between the line sampler, the NRZI de-stuffing receiver and the
//   byte layer.
//
//   Sampler -> receiver:
//     line_in        sampled line level, meaningful only with line_valid
//     line_valid     one-cycle strobe, one line bit per strobe
//     frame          high while a packet is on the line
//   Receiver -> byte layer:
//     data_byte      last assembled byte (LSB = first data bit), held
//     byte_valid     one-cycle pulse, data_byte is new this cycle
//     stuff_err      one-cycle pulse on a stuffing violation
//     eop            one-cycle pulse when the frame ends
//     trailing_bits  data bits of the unfinished byte at frame end (with eop)
//
//   master: the side that feeds line samples and consumes decoded bytes.
//   slave : the receiver itself.
// -----------------------------------------------------------------------------
interface nrzi_destuff_rx_if;
    logic       line_in;
    logic       line_valid;
    logic       frame;
    logic [7:0] data_byte;
    logic       byte_valid;
    logic       stuff_err;
    logic       eop;
    logic [2:0] trailing_bits;

    modport master (
        output line_in,
        output line_valid,
        output frame,
        input  data_byte,
        input  byte_valid,
        input  stuff_err,
        input  eop,
        input  trailing_bits
    );

    modport slave (
        input  line_in,
        input  line_valid,
        input  frame,
        output data_byte,
        output byte_valid,
        output stuff_err,
        output eop,
        output trailing_bits
    );
endinterface

// File: rtl/nrzi_destuff_rx.sv
// -----------------------------------------------------------------------------
// nrzi_destuff_rx
//   Receive-side NRZI decoder with bit de-stuffing and LSB-first byte assembly.
//   A line level equal to the previous level decodes as 1, a change as 0.
//   After STUFF_LEN consecutive decoded 1s the transmitter inserts a 0, which
//   is checked and dropped here; a 1 in that slot is a stuffing violation and
//   the rest of the frame is ignored.
//
//   Parameters:
//     STUFF_LEN   consecutive 1s after which the next bit is a stuffed bit
//     IDLE_LEVEL  line level assumed before the first bit of a frame
//
//   Ports:
//     clk       system clock, all state on the rising edge
//     areset_n  asynchronous active-low reset
//     rx        nrzi_destuff_rx_if.slave (line samples in, bytes/status out)
//
//   All outputs are registered: byte_valid, stuff_err and eop appear on the
//   cycle after the clock edge that accepted the corresponding strobe/frame
//   fall.
// -----------------------------------------------------------------------------
module nrzi_destuff_rx #(
    parameter int unsigned STUFF_LEN  = 6,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             areset_n,
    nrzi_destuff_rx_if.slave rx
);

    localparam int unsigned       ONES_W      = $clog2(STUFF_LEN + 1);
    localparam logic [ONES_W-1:0] STUFF_LEN_C = ONES_W'(STUFF_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STUFF = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic              prev_level_q, prev_level_d;
    logic [ONES_W-1:0] ones_cnt_q,   ones_cnt_d;
    logic [2:0]        bit_cnt_q,    bit_cnt_d;
    logic [7:0]        shift_q,      shift_d;
    logic [7:0]        data_byte_q,  data_byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              stuff_err_q,  stuff_err_d;
    logic              eop_q,        eop_d;
    logic [2:0]        trailing_q,   trailing_d;

    logic              ref_level;
    logic              dec_bit;
    logic              take_data;
    logic [ONES_W-1:0] ones_inc;

    // The first bit of a frame is decoded against the idle level even when it
    // arrives in the same cycle as the frame rise.
    always_comb begin
        ref_level = (state_q == S_IDLE) ? IDLE_LEVEL : prev_level_q;
        dec_bit   = (rx.line_in == ref_level);
        ones_inc  = ones_cnt_q + ONES_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        prev_level_d = prev_level_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_byte_d  = data_byte_q;
        trailing_d   = trailing_q;
        byte_valid_d = 1'b0;
        stuff_err_d  = 1'b0;
        eop_d        = 1'b0;
        take_data    = 1'b0;

        case (state_q)
            S_IDLE: begin
                prev_level_d = IDLE_LEVEL;
                ones_cnt_d   = '0;
                bit_cnt_d    = '0;
                shift_d      = '0;
                if (rx.frame) begin
                    state_d   = S_RUN;
                    take_data = rx.line_valid;
                end
            end

            S_RUN: begin
                if (rx.frame) begin
                    take_data = rx.line_valid;
                end
            end

            // The bit after a full run of ones must be a 0; it carries no data
            // but still updates the line reference level.
            S_STUFF: begin
                if (rx.frame && rx.line_valid) begin
                    prev_level_d = rx.line_in;
                    if (dec_bit) begin
                        stuff_err_d = 1'b1;
                        state_d     = S_ERR;
                    end else begin
                        ones_cnt_d = '0;
                        state_d    = S_RUN;
                    end
                end
            end

            S_ERR: begin
                // Everything on the line is ignored until the frame ends.
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame fall wins over any strobe in the same cycle; the unfinished
        // byte is dropped and only its bit count is reported.
        if ((state_q != S_IDLE) && !rx.frame) begin
            state_d      = S_IDLE;
            eop_d        = 1'b1;
            trailing_d   = (state_q == S_ERR) ? 3'd0 : bit_cnt_q;
            prev_level_d = IDLE_LEVEL;
            ones_cnt_d   = '0;
            bit_cnt_d    = '0;
            shift_d      = '0;
        end

        // Data bit: lands at position bit_cnt, LSB first. The ones run is not
        // reset at byte boundaries, so stuffing spans bytes.
        if (take_data) begin
            prev_level_d       = rx.line_in;
            shift_d[bit_cnt_q] = dec_bit;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                data_byte_d  = shift_d;
                byte_valid_d = 1'b1;
            end
            if (dec_bit) begin
                ones_cnt_d = ones_inc;
                if (ones_inc == STUFF_LEN_C) begin
                    state_d = S_STUFF;
                end
            end else begin
                ones_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= S_IDLE;
            prev_level_q <= IDLE_LEVEL;
            ones_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_byte_q  <= '0;
            byte_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
            eop_q        <= 1'b0;
            trailing_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_level_q <= prev_level_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_byte_q  <= data_byte_d;
            byte_valid_q <= byte_valid_d;
            stuff_err_q  <= stuff_err_d;
            eop_q        <= eop_d;
            trailing_q   <= trailing_d;
        end
    end

    assign rx.data_byte     = data_byte_q;
    assign rx.byte_valid    = byte_valid_q;
    assign rx.stuff_err     = stuff_err_q;
    assign rx.eop           = eop_q;
    assign rx.trailing_bits = trailing_q;

endmodule

// File: tb/tb_nrzi_destuff_rx.sv
// -----------------------------------------------------------------------------
// tb_nrzi_destuff_rx
//   Self-checking bench for nrzi_destuff_rx: a table of directed frames, a few
//   hand-timed sequences (latency, stuff_err timing, async reset) and random
//   frames produced by an NRZI/stuffing encoder and checked against a
//   queue-based decoding model.
// -----------------------------------------------------------------------------
module tb_nrzi_destuff_rx;

    localparam int STUFF_LEN = 6;

    logic clk      = 1'b0;
    logic areset_n = 1'b0;
    always #5 clk = ~clk;

    nrzi_destuff_rx_if bus ();

    nrzi_destuff_rx #(
        .STUFF_LEN (STUFF_LEN),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk     (clk),
        .areset_n(areset_n),
        .rx      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Output monitor, sampled on the falling edge.
    logic [7:0] got_bytes[$];
    int         got_err   = 0;
    int         got_eop   = 0;
    logic [2:0] got_trail = 3'd0;

    always @(negedge clk) begin
        if (areset_n) begin
            if (bus.byte_valid) got_bytes.push_back(bus.data_byte);
            if (bus.stuff_err)  got_err++;
            if (bus.eop) begin
                got_eop++;
                got_trail = bus.trailing_bits;
            end
        end
    end

    // Stimulus and expectations for the current frame.
    bit         lv_q[$];
    logic [7:0] exp_bytes[$];
    int         exp_err;
    logic [2:0] exp_trail;

    typedef struct {
        string      name;
        string      levels;
        bit         fall_vld;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         err;
        logic [2:0] trail;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit lvl);
        bus.frame      = 1'b1;
        bus.line_valid = 1'b1;
        bus.line_in    = lvl;
        tick();
        bus.line_valid = 1'b0;
    endtask

    task automatic end_frame(input bit fall_vld);
        bus.frame      = 1'b0;
        bus.line_valid = fall_vld;
        bus.line_in    = 1'($urandom);
        tick();
        bus.line_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic drive_frame(input int gap_max, input bit fall_vld);
        for (int i = 0; i < lv_q.size(); i++) begin
            strobe(lv_q[i]);
            repeat ($urandom_range(gap_max, 0)) begin
                bus.line_in = 1'($urandom);
                tick();
            end
        end
        end_frame(fall_vld);
    endtask

    task automatic load_levels(input string s);
        lv_q.delete();
        for (int i = 0; i < s.len(); i++) lv_q.push_back(s.getc(i) == "1");
    endtask

    // Transmit side: NRZI toggles on 0, holds on 1; a 0 is inserted after
    // STUFF_LEN consecutive ones.
    task automatic encode_random(input int nb);
        bit         level;
        int         run;
        logic [7:0] d;
        level = 1'b1;
        run   = 0;
        lv_q.delete();
        for (int j = 0; j < nb; j++) begin
            d = ($urandom_range(2, 0) == 0) ? 8'hFF : 8'($urandom);
            for (int k = 0; k < 8; k++) begin
                if (!d[k]) level = !level;
                lv_q.push_back(level);
                run = d[k] ? run + 1 : 0;
                if (run == STUFF_LEN) begin
                    level = !level;
                    lv_q.push_back(level);
                    run = 0;
                end
            end
        end
    endtask

    // Receive-side reference: decode the whole level list, collect data bits,
    // group them into bytes afterwards.
    task automatic model_decode();
        bit         prev;
        bit         d;
        int         run;
        bit         data_bits[$];
        logic [7:0] b;
        prev    = 1'b1;
        run     = 0;
        exp_err = 0;
        exp_bytes.delete();
        for (int i = 0; i < lv_q.size() && exp_err == 0; i++) begin
            d    = (lv_q[i] == prev);
            prev = lv_q[i];
            if (run == STUFF_LEN) begin
                if (d) exp_err = 1;
                run = 0;
            end else begin
                data_bits.push_back(d);
                run = d ? run + 1 : 0;
            end
        end
        for (int j = 0; j + 8 <= data_bits.size(); j += 8) begin
            for (int k = 0; k < 8; k++) b[k] = data_bits[j + k];
            exp_bytes.push_back(b);
        end
        exp_trail = (exp_err != 0) ? 3'd0 : 3'(data_bits.size() % 8);
    endtask

    task automatic compare_frame(input string name, input int b0, input int e0, input int p0);
        check({name, ":byte_count"}, 32'(got_bytes.size() - b0), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && (b0 + i) < got_bytes.size(); i++)
            check({name, ":data_byte"}, 32'(got_bytes[b0 + i]), 32'(exp_bytes[i]));
        check({name, ":stuff_err"}, 32'(got_err - e0), 32'(exp_err));
        check({name, ":eop"},       32'(got_eop - p0), 32'd1);
        check({name, ":trailing"},  32'(got_trail),    32'(exp_trail));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int b0, e0, p0;

        tbl[0] = '{"a5",            "10010011",           1'b0, 1, 8'hA5, 8'h00, 0, 3'd0};
        tbl[1] = '{"ff_stuffed",    "111111000",          1'b0, 1, 8'hFF, 8'h00, 0, 3'd0};
        tbl[2] = '{"stuff_viol",    "11111110101",        1'b0, 0, 8'h00, 8'h00, 1, 3'd0};
        tbl[3] = '{"partial_fallv", "011",                1'b1, 0, 8'h00, 8'h00, 0, 3'd3};
        tbl[4] = '{"first_bit_one", "10101010",           1'b0, 1, 8'h01, 8'h00, 0, 3'd0};
        tbl[5] = '{"cross_byte",    "010111111100000001", 1'b0, 2, 8'hF0, 8'hFF, 0, 3'd0};
        tbl[6] = '{"fall_in_err",   "1111111",            1'b1, 0, 8'h00, 8'h00, 1, 3'd0};
        tbl[7] = '{"fall_in_stuff", "111111",             1'b0, 0, 8'h00, 8'h00, 0, 3'd6};

        bus.frame      = 1'b0;
        bus.line_valid = 1'b0;
        bus.line_in    = 1'b1;

        // Reset state.
        #12;
        check("rst:data_byte",     32'(bus.data_byte),     32'h0);
        check("rst:byte_valid",    32'(bus.byte_valid),    32'h0);
        check("rst:stuff_err",     32'(bus.stuff_err),     32'h0);
        check("rst:eop",           32'(bus.eop),           32'h0);
        check("rst:trailing_bits", 32'(bus.trailing_bits), 32'h0);
        #10;
        areset_n = 1'b1;
        tick();

        // Directed table, back-to-back strobes.
        for (int t = 0; t < 8; t++) begin
            load_levels(tbl[t].levels);
            exp_bytes.delete();
            if (tbl[t].nbytes > 0) exp_bytes.push_back(tbl[t].b0);
            if (tbl[t].nbytes > 1) exp_bytes.push_back(tbl[t].b1);
            exp_err   = tbl[t].err;
            exp_trail = tbl[t].trail;
            b0 = got_bytes.size();
            e0 = got_err;
            p0 = got_eop;
            drive_frame(0, tbl[t].fall_vld);
            compare_frame(tbl[t].name, b0, e0, p0);
        end

        // byte_valid appears right after the 8th strobe edge, for one cycle.
        load_levels("10010011");
        for (int i = 0; i < 8; i++) begin
            strobe(lv_q[i]);
            if (i < 7) check("lat:no_early_byte_valid", 32'(bus.byte_valid), 32'h0);
        end
        check("lat:byte_valid", 32'(bus.byte_valid), 32'h1);
        check("lat:data_byte",  32'(bus.data_byte),  32'hA5);
        tick();
        check("lat:byte_valid_pulse", 32'(bus.byte_valid), 32'h0);
        check("lat:data_byte_held",   32'(bus.data_byte),  32'hA5);
        end_frame(1'b0);

        // stuff_err on the cycle after the 7th one, single pulse.
        for (int i = 0; i < 7; i++) begin
            strobe(1'b1);
            if (i < 6) check("viol:no_early_err", 32'(bus.stuff_err), 32'h0);
        end
        check("viol:stuff_err", 32'(bus.stuff_err), 32'h1);
        strobe(1'b0);
        check("viol:stuff_err_pulse", 32'(bus.stuff_err), 32'h0);
        end_frame(1'b0);

        // Leave trailing_bits nonzero, then reset asynchronously mid-byte.
        load_levels("011");
        drive_frame(0, 1'b0);
        check("pre_rst:trailing_bits", 32'(bus.trailing_bits), 32'h3);
        load_levels("10010");
        for (int i = 0; i < 5; i++) strobe(lv_q[i]);
        #3;
        areset_n = 1'b0;
        #1;
        check("arst:data_byte",     32'(bus.data_byte),     32'h0);
        check("arst:byte_valid",    32'(bus.byte_valid),    32'h0);
        check("arst:stuff_err",     32'(bus.stuff_err),     32'h0);
        check("arst:eop",           32'(bus.eop),           32'h0);
        check("arst:trailing_bits", 32'(bus.trailing_bits), 32'h0);
        bus.frame = 1'b0;
        #2;
        areset_n = 1'b1;
        tick();
        load_levels("10010011");
        exp_bytes.delete();
        exp_bytes.push_back(8'hA5);
        exp_err   = 0;
        exp_trail = 3'd0;
        b0 = got_bytes.size();
        e0 = got_err;
        p0 = got_eop;
        drive_frame(0, 1'b0);
        compare_frame("after_rst_a5", b0, e0, p0);

        // Random frames with gaps, occasional corruption and truncation.
        for (int f = 0; f < 60; f++) begin
            int k;
            encode_random($urandom_range(4, 1));
            if ($urandom_range(3, 0) == 0) begin
                k = $urandom_range(lv_q.size() - 1, 0);
                lv_q[k] = !lv_q[k];
            end
            if ($urandom_range(3, 0) == 0) begin
                k = $urandom_range(lv_q.size() - 1, 1);
                while (lv_q.size() > k) void'(lv_q.pop_back());
            end
            model_decode();
            b0 = got_bytes.size();
            e0 = got_err;
            p0 = got_eop;
            drive_frame($urandom_range(2, 0), 1'($urandom));
            compare_frame($sformatf("rand%0d", f), b0, e0, p0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
